// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the I-cache.
// The fetch side drives the request; the cache returns one data strobe per request.
interface fetch_unit_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_valid
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the I-cache, fills the IF/ID register, absorbs
// stalls through a one-entry hold buffer, and handles branch redirects and HLT.
module fetch_unit (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic [15:0]        if_id_instr,
  output logic [15:0]        if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] req_addr_reg;
  logic        outstanding_reg;
  logic        discard_reg;
  logic [15:0] hold_instr_reg;
  logic [15:0] hold_pc2_reg;
  logic [15:0] if_id_instr_reg;
  logic [15:0] if_id_pc2_reg;
  logic        if_id_valid_reg;
  logic        halted_reg;

  logic [15:0] pc_next;
  logic [15:0] req_pc2;
  logic        outstanding_next;
  logic        in_flight;
  logic        resp_hlt;
  logic        hold_hlt;
  logic        accept_resp;
  logic        release_hold;
  logic        rd;

  // Request is gated by rst_n so nothing is presented to the cache during reset.
  assign rd             = rst_n && (state_reg == FETCH);
  assign imem.imem_rd   = rd;
  assign imem.imem_addr = req_addr_reg;

  assign if_id_instr    = if_id_instr_reg;
  assign if_id_pc_plus2 = if_id_pc2_reg;
  assign if_id_valid    = if_id_valid_reg;
  assign halted         = halted_reg;

  assign req_pc2          = req_addr_reg + 16'd2;
  assign resp_hlt         = (imem.imem_data[15:12] == HLT_OPCODE);
  assign hold_hlt         = (hold_instr_reg[15:12] == HLT_OPCODE);
  assign outstanding_next = rd && !imem.imem_valid;
  // A request the cache has already taken but not yet answered.
  assign in_flight        = (outstanding_reg || rd) && !imem.imem_valid;

  assign accept_resp  = (state_reg == FETCH) && imem.imem_valid && !discard_reg && !stall;
  assign release_hold = (state_reg == HOLD) && !stall;

  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (accept_resp && !resp_hlt) begin
      pc_next = req_pc2;
    end else if (release_hold && !hold_hlt) begin
      pc_next = hold_pc2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= FETCH;
      pc_reg          <= 16'h0000;
      req_addr_reg    <= 16'h0000;
      outstanding_reg <= 1'b0;
      discard_reg     <= 1'b0;
      hold_instr_reg  <= 16'h0000;
      hold_pc2_reg    <= 16'h0000;
      if_id_instr_reg <= 16'h0000;
      if_id_pc2_reg   <= 16'h0000;
      if_id_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      // Address is frozen for the whole of a miss.
      if (!outstanding_next) begin
        req_addr_reg <= pc_next;
      end

      if (redirect) begin
        state_reg       <= FETCH;
        if_id_valid_reg <= 1'b0;
        if_id_instr_reg <= 16'h0000;
        halted_reg      <= 1'b0;
        discard_reg     <= in_flight;
      end else begin
        case (state_reg)
          FETCH: begin
            if (imem.imem_valid) begin
              if (discard_reg) begin
                discard_reg <= 1'b0;
              end else if (stall) begin
                hold_instr_reg <= imem.imem_data;
                hold_pc2_reg   <= req_pc2;
                state_reg      <= HOLD;
              end else begin
                if_id_instr_reg <= imem.imem_data;
                if_id_pc2_reg   <= req_pc2;
                if_id_valid_reg <= 1'b1;
                if (resp_hlt) begin
                  state_reg  <= HALTED;
                  halted_reg <= 1'b1;
                end
              end
            end else if (!stall) begin
              if_id_valid_reg <= 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              if_id_instr_reg <= hold_instr_reg;
              if_id_pc2_reg   <= hold_pc2_reg;
              if_id_valid_reg <= 1'b1;
              if (hold_hlt) begin
                state_reg  <= HALTED;
                halted_reg <= 1'b1;
              end else begin
                state_reg <= FETCH;
              end
            end
          end
          HALTED: begin
            if (!stall) begin
              if_id_valid_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the I-cache cycle by cycle and
// checks request address/strobe and IF/ID contents against hand-computed values.
module tb_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  int passed;
  int total;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic st,
                       input logic rdr, input logic [15:0] rpc);
    imem.imem_valid = v;
    imem.imem_data  = d;
    stall           = st;
    redirect        = rdr;
    redirect_pc     = rpc;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr,
                          input logic [15:0] pc2, input logic v);
    chk(tag, {if_id_instr, if_id_pc_plus2, if_id_valid}, {instr, pc2, v});
  endtask

  task automatic chk_req(input string tag, input logic rd, input logic [15:0] addr);
    chk(tag, {16'h0000, imem.imem_rd, imem.imem_addr}, {16'h0000, rd, addr});
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();

    // Reset state
    chk_req("rst_req", 1'b0, 16'h0000);
    chk_ifid("rst_ifid", 16'h0000, 16'h0000, 1'b0);
    chk("rst_halted", {32'h0, halted}, 33'h0);

    // Back-to-back hits after reset release
    rst_n = 1'b1;
    #1;
    chk_req("first_req", 1'b1, 16'h0000);
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("hit0_ifid", 16'h1111, 16'h0002, 1'b1);
    chk_req("hit1_req", 1'b1, 16'h0002);
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("hit1_ifid", 16'h2222, 16'h0004, 1'b1);
    chk_req("hit2_req", 1'b1, 16'h0004);

    // Redirect coinciding with a response: response dropped, no discard
    drive(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0010);
    tick();
    chk_ifid("rdr_drop_ifid", 16'h0000, 16'h0004, 1'b0);
    chk_req("rdr_drop_req", 1'b1, 16'h0010);

    // Four-cycle miss at 0x0010
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      tick();
      chk_req("miss_req", 1'b1, 16'h0010);
      chk("miss_bubble", {32'h0, if_id_valid}, 33'h0);
    end
    drive(1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("miss_ifid", 16'hA5A5, 16'h0012, 1'b1);
    chk_req("miss_next_req", 1'b1, 16'h0012);

    // Stall as the response arrives, held three cycles
    drive(1'b1, 16'h3333, 1'b1, 1'b0, 16'h0000);
    tick();
    chk_req("hold_req", 1'b0, 16'h0012);
    chk_ifid("hold_ifid", 16'hA5A5, 16'h0012, 1'b1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tick();
    tick();
    chk_req("hold3_req", 1'b0, 16'h0012);
    chk_ifid("hold3_ifid", 16'hA5A5, 16'h0012, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("unhold_ifid", 16'h3333, 16'h0014, 1'b1);
    chk_req("unhold_req", 1'b1, 16'h0014);

    // Stall with no response holds IF/ID; then the hit lands
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    tick();
    chk_ifid("stall_miss_ifid", 16'h3333, 16'h0014, 1'b1);
    chk_req("stall_miss_req", 1'b1, 16'h0014);
    drive(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("after_stall", 16'h4444, 16'h0016, 1'b1);

    // Redirect during an outstanding miss at 0x0020
    drive(1'b1, 16'h0BAD, 1'b0, 1'b1, 16'h0020);
    tick();
    chk_req("to20_req", 1'b1, 16'h0020);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
    tick();
    chk_req("disc_hold_req", 1'b1, 16'h0020);
    chk_ifid("disc_rdr_ifid", 16'h0000, 16'h0016, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b1, 16'hBAD0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("disc_drop_ifid", 16'h0000, 16'h0016, 1'b0);
    chk_req("disc_next_req", 1'b1, 16'h0100);
    drive(1'b1, 16'h5555, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("post_disc_ifid", 16'h5555, 16'h0102, 1'b1);

    // HLT at 0x0030
    drive(1'b1, 16'h0BAD, 1'b0, 1'b1, 16'h0030);
    tick();
    chk_req("to30_req", 1'b1, 16'h0030);
    drive(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("hlt_ifid", 16'hF000, 16'h0032, 1'b1);
    chk("hlt_halted", {32'h0, halted}, 33'h1);
    chk_req("hlt_req", 1'b0, 16'h0030);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    chk("halt_bubble", {if_id_valid, 31'h0, halted}, {1'b0, 31'h0, 1'b1});
    chk_req("halt_idle_req", 1'b0, 16'h0030);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040);
    tick();
    chk("unhalt", {32'h0, halted}, 33'h0);
    chk_req("unhalt_req", 1'b1, 16'h0040);
    drive(1'b1, 16'h6666, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("unhalt_ifid", 16'h6666, 16'h0042, 1'b1);

    // PC wrap at 0xFFFE
    drive(1'b1, 16'h0BAD, 1'b0, 1'b1, 16'hFFFE);
    tick();
    chk_req("wrap_req", 1'b1, 16'hFFFE);
    drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("wrap_ifid", 16'h7777, 16'h0000, 1'b1);
    chk_req("wrap_next_req", 1'b1, 16'h0000);

    // Back-to-back redirects: the last one wins
    drive(1'b1, 16'h0BAD, 1'b0, 1'b1, 16'h0200);
    tick();
    drive(1'b1, 16'h0BAD, 1'b0, 1'b1, 16'h0300);
    tick();
    chk_req("rdr2_req", 1'b1, 16'h0300);
    drive(1'b1, 16'h8888, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_ifid("rdr2_ifid", 16'h8888, 16'h0302, 1'b1);

    // Reset asserted mid-miss
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b0;
    #1;
    chk_req("midrst_req", 1'b0, 16'h0000);
    chk_ifid("midrst_ifid", 16'h0000, 16'h0000, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    drive(1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000);
    chk_req("rerst_req", 1'b1, 16'h0000);
    tick();
    chk_ifid("rerst_ifid", 16'h9999, 16'h0002, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port stall, input, 1 bit: hazard unit requests that the IF/ID contents be held.
REQ-005 Port redirect, input, 1 bit: branch-taken flush from the decode-stage branch control.
REQ-006 Port redirect_pc, input, 16 bits: next PC, valid when redirect=1.
REQ-007 Port imem_rd, output, 1 bit: instruction-cache read request.
REQ-008 Port imem_addr, output, 16 bits: byte address of the request.
REQ-009 Port imem_data, input, 16 bits: instruction word, valid when imem_valid=1.
REQ-010 Port imem_valid, input, 1 bit: cache response strobe, one cycle per request, after 1 to N cycles (miss).
REQ-011 Port if_id_instr, output, 16 bits: instruction in the IF/ID register.
REQ-012 Port if_id_pc_plus2, output, 16 bits: fetch address + 2, consumed by branch control as its base PC.
REQ-013 Port if_id_valid, output, 1 bit: IF/ID holds a real instruction; 0 means bubble.
REQ-014 Port halted, output, 1 bit: a HLT instruction (opcode imem_data[15:12]=4'hF) has been fetched and fetch has stopped.

Function
REQ-015 The block SHALL use registers pc[15:0], req_addr[15:0], an outstanding flag, a discard flag, and a one-entry hold buffer (instruction and pc_plus2).
REQ-016 The FSM SHALL have three states: FETCH, HOLD and HALTED; the reset state SHALL be FETCH.
REQ-017 In FETCH, imem_rd SHALL be 1; in HOLD and HALTED, imem_rd SHALL be 0.
REQ-018 imem_addr SHALL equal req_addr.
REQ-019 req_addr SHALL load pc only when no request is outstanding, so the address stays stable for the whole of a miss.
REQ-020 outstanding SHALL set when imem_rd=1 and imem_valid=0, and SHALL clear on imem_valid.
REQ-021 Address arithmetic SHALL be 16-bit modulo: pc+2 wraps 16'hFFFE to 16'h0000 with no carry out.
REQ-022 FETCH, imem_valid=1, stall=0, discard=0, no HLT: IF/ID SHALL load {imem_data, req_addr+2, valid=1}, pc SHALL become req_addr+2, and the next cycle SHALL issue a new request (back-to-back hits give 1 instruction per cycle).
REQ-023 FETCH, imem_valid=1, stall=1: the response SHALL be captured into the hold buffer, the state SHALL go to HOLD, and IF/ID SHALL be unchanged.
REQ-024 HOLD, stall=0: IF/ID SHALL load from the hold buffer with valid=1, pc SHALL become buffer pc_plus2, and the state SHALL return to FETCH.
REQ-025 FETCH, imem_valid=0: if stall=0, if_id_valid SHALL be 0 (bubble); if stall=1, IF/ID SHALL be held.
REQ-026 HLT accepted into IF/ID (either path): the state SHALL go to HALTED, pc SHALL NOT increment, and halted SHALL be 1.
REQ-027 HALTED: if_id_valid SHALL clear once the HLT word leaves (stall=0); the state SHALL be left only by redirect.
REQ-028 redirect=1 SHALL take priority over stall, imem_valid and all states: pc SHALL become redirect_pc, if_id_valid SHALL become 0, if_id_instr SHALL become 16'h0000, the hold buffer SHALL be dropped, halted SHALL become 0, and the state SHALL become FETCH.
REQ-029 redirect while outstanding=1 and imem_valid=0 SHALL set discard.
REQ-030 While discard=1, the next imem_valid SHALL be dropped (no IF/ID or pc update) and discard SHALL clear; the request to redirect_pc SHALL issue the following cycle.
REQ-031 redirect in the same cycle as imem_valid SHALL drop that response with no discard set.
REQ-032 Second back-to-back redirects: the last one SHALL win.

Reset
REQ-033 While rst_n=0: pc, req_addr, if_id_instr and if_id_pc_plus2 SHALL be 16'h0000; if_id_valid, halted, outstanding and discard SHALL be 0; the state SHALL be FETCH; imem_rd SHALL be 0.
REQ-034 The first request (addr 16'h0000) SHALL issue in the first cycle after rst_n rises.
REQ-035 Reset asserted mid-miss SHALL abandon the request; the cache is reset by the same rst_n.

Verification
REQ-036 Reset release with single-cycle hits of 16'h1111 and 16'h2222 -> imem_addr 0, then 2; IF/ID shows {16'h1111, 16'h0002, valid=1}, then {16'h2222, 16'h0004, valid=1}.
REQ-037 Miss of 4 cycles at addr 16'h0010 -> imem_addr held at 16'h0010 for 4 cycles with if_id_valid=0, then IF/ID shows {data, 16'h0012, valid=1}.
REQ-038 stall=1 when imem_valid arrives, held 3 cycles -> state HOLD, imem_rd=0, IF/ID unchanged; on stall drop IF/ID shows the buffered word and pc advances by 2.
REQ-039 redirect to 16'h0100 during an outstanding miss at 16'h0020 -> the late response is discarded and never reaches IF/ID; the next request is at 16'h0100.
REQ-040 Fetch of 16'hF000 at 16'h0030 -> halted=1, imem_rd=0, pc=16'h0030; a later redirect to 16'h0040 -> halted=0 and a fetch at 16'h0040.
REQ-041 pc=16'hFFFE with a hit -> if_id_pc_plus2=16'h0000 and the next request is at 16'h0000.
